// File: rtl/f_divider_back.sv
// Divide unit back end: normalise, denormalise and round the raw quotient
// into a packed IEEE-754 result with MIPS FCSR cause flags.
module f_divider_back #(
  parameter int info_width = 1,
  parameter int exp_width  = 11,
  parameter int frac_width = 52
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              a_wait,
  input  logic                              flush,
  input  logic [exp_width+1:0]              in_exp,
  input  logic [2*frac_width+3:0]           in_frac,
  input  logic                              in_sign,
  input  logic                              in_invalid,
  input  logic                              in_divbyzero,
  input  logic [info_width-1:0]             info_in,
  input  logic [1:0]                        rm,
  output logic                              busy,
  output logic [exp_width+frac_width:0]     result,
  output logic [info_width-1:0]             info_out,
  output logic                              f_invalid,
  output logic                              f_divbyzero,
  output logic                              f_overflow,
  output logic                              f_underflow,
  output logic                              f_inexact
);

  localparam int EW = exp_width;
  localparam int FW = frac_width;
  localparam int QW = 2*FW+4;
  localparam int IP = QW-3;
  localparam int XW = EW+4;
  localparam int RW = EW+FW+1;

  localparam logic signed [XW-1:0] ONE  = XW'(1);
  localparam logic signed [XW-1:0] EMAX = XW'(2**EW-1);
  localparam logic signed [XW-1:0] DBIG = XW'(FW+3);
  localparam logic signed [XW-1:0] D16  = XW'(16);

  localparam logic [1:0] RM_RN = 2'd0;
  localparam logic [1:0] RM_RZ = 2'd1;
  localparam logic [1:0] RM_RP = 2'd2;
  localparam logic [1:0] RM_RM = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_NORM, S_DENORM, S_ROUND, S_OUT
  } state_t;

  state_t                 r_state, w_state;
  logic signed [XW-1:0]   r_exp, w_exp;
  logic [QW-1:0]          r_frac, w_frac;
  logic                   r_sticky, w_sticky;
  logic                   r_tiny, w_tiny;
  logic [RW-1:0]          r_res, w_res;
  logic [4:0]             r_flg, w_flg;
  logic                   r_sign, r_inv, r_dbz, r_zero;
  logic [1:0]             r_rm;
  logic [info_width-1:0]  r_info;
  logic                   w_accept, w_fire;

  // Rounding datapath, evaluated from the registered packet
  logic [FW:0]            w_mant;
  logic                   w_guard, w_st, w_inc, w_carry, w_inx, w_ovf;
  logic                   w_maxfin;
  logic [FW+1:0]          w_msum;
  logic [FW:0]            w_mfin;
  logic signed [XW-1:0]   w_efin;
  logic [EW-1:0]          w_efield;

  assign w_mant  = r_frac[IP -: FW+1];
  assign w_guard = r_frac[FW];
  assign w_st    = (|r_frac[FW-1:0]) | r_sticky;
  assign w_inx   = w_guard | w_st;

  always_comb begin
    w_inc = 1'b0;
    unique case (r_rm)
      RM_RN: w_inc = w_guard & (w_st | w_mant[0]);
      RM_RZ: w_inc = 1'b0;
      RM_RP: w_inc = ~r_sign & w_inx;
      RM_RM: w_inc = r_sign & w_inx;
      default: w_inc = 1'b0;
    endcase
  end

  assign w_msum   = {1'b0, w_mant} + (FW+2)'(w_inc);
  assign w_carry  = w_msum[FW+1];
  assign w_mfin   = w_carry ? w_msum[FW+1:1] : w_msum[FW:0];
  assign w_efin   = r_exp + (w_carry ? ONE : '0);
  assign w_ovf    = w_efin >= EMAX;
  assign w_efield = w_mfin[FW] ? w_efin[EW-1:0] : '0;
  assign w_maxfin = (r_rm == RM_RZ)
                  | ((r_rm == RM_RP) & r_sign)
                  | ((r_rm == RM_RM) & ~r_sign);

  // Right-shift amount and lost bits while denormalising
  logic signed [XW-1:0]   w_dsh;
  logic                   w_big;
  logic [4:0]             w_rsh;
  logic [QW-1:0]          w_mask;
  logic                   w_lost;

  assign w_dsh  = ONE - r_exp;
  assign w_big  = w_dsh > DBIG;
  assign w_rsh  = (w_dsh > D16) ? 5'd16 : w_dsh[4:0];
  assign w_mask = (QW'(1) << w_rsh) - QW'(1);
  assign w_lost = |(r_frac & w_mask);

  logic [4:0] w_lsh;

  always_comb begin
    if (r_frac[IP -: 16] == '0)     w_lsh = 5'd16;
    else if (r_frac[IP -: 8] == '0) w_lsh = 5'd8;
    else if (r_frac[IP -: 4] == '0) w_lsh = 5'd4;
    else if (r_frac[IP-1])          w_lsh = 5'd1;
    else if (r_frac[IP-2])          w_lsh = 5'd2;
    else                            w_lsh = 5'd3;
  end

  always_comb begin
    w_state  = r_state;
    w_exp    = r_exp;
    w_frac   = r_frac;
    w_sticky = r_sticky;
    w_tiny   = r_tiny;
    w_res    = r_res;
    w_flg    = r_flg;
    w_accept = 1'b0;
    w_fire   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (info_in[0] & ~a_wait & ~flush) begin
          w_accept = 1'b1;
          w_exp    = {{2{in_exp[EW+1]}}, in_exp};
          w_frac   = in_frac;
          w_sticky = 1'b0;
          w_tiny   = 1'b0;
          // specials and zero take a single pass through ROUND
          if (in_invalid | in_divbyzero | (in_frac == '0))
            w_state = S_ROUND;
          else
            w_state = S_NORM;
        end
      end
      S_NORM: begin
        if (r_frac[QW-1:QW-2] != 2'b00) begin
          w_frac   = r_frac >> 1;
          w_exp    = r_exp + ONE;
          w_sticky = r_sticky | r_frac[0];
        end else if (!r_frac[IP]) begin
          w_frac = r_frac << w_lsh;
          w_exp  = r_exp - XW'(w_lsh);
        end else begin
          w_tiny  = r_exp < ONE;
          w_state = S_DENORM;
        end
      end
      S_DENORM: begin
        if (r_exp >= ONE) begin
          w_state = S_ROUND;
        end else if (w_big) begin
          w_sticky = r_sticky | (|r_frac);
          w_frac   = '0;
          w_exp    = ONE;
        end else begin
          w_frac   = r_frac >> w_rsh;
          w_sticky = r_sticky | w_lost;
          w_exp    = r_exp + XW'(w_rsh);
        end
      end
      S_ROUND: begin
        w_state = S_OUT;
        if (r_inv) begin
          w_res = {1'b0, {EW{1'b1}}, 1'b0, {(FW-1){1'b1}}};
          w_flg = 5'b10000;
        end else if (r_dbz) begin
          w_res = {r_sign, {EW{1'b1}}, {FW{1'b0}}};
          w_flg = 5'b01000;
        end else if (r_zero) begin
          w_res = {r_sign, {(RW-1){1'b0}}};
          w_flg = 5'b00000;
        end else if (w_ovf) begin
          w_res = w_maxfin
                ? {r_sign, {(EW-1){1'b1}}, 1'b0, {FW{1'b1}}}
                : {r_sign, {EW{1'b1}}, {FW{1'b0}}};
          w_flg = 5'b00101;
        end else begin
          w_res = {r_sign, w_efield, w_mfin[FW-1:0]};
          w_flg = {2'b00, 1'b0, r_tiny & w_inx, w_inx};
        end
      end
      S_OUT: begin
        if (!a_wait) begin
          w_fire  = 1'b1;
          w_state = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
    if (flush) begin
      w_state = S_IDLE;
      w_fire  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_exp    <= '0;
      r_frac   <= '0;
      r_sticky <= 1'b0;
      r_tiny   <= 1'b0;
      r_res    <= '0;
      r_flg    <= '0;
      r_sign   <= 1'b0;
      r_inv    <= 1'b0;
      r_dbz    <= 1'b0;
      r_zero   <= 1'b0;
      r_rm     <= '0;
      r_info   <= '0;
    end else begin
      r_state  <= w_state;
      r_exp    <= w_exp;
      r_frac   <= w_frac;
      r_sticky <= w_sticky;
      r_tiny   <= w_tiny;
      r_res    <= w_res;
      r_flg    <= w_flg;
      if (w_accept) begin
        r_sign <= in_sign;
        r_inv  <= in_invalid;
        r_dbz  <= in_divbyzero;
        r_zero <= in_frac == '0;
        r_rm   <= rm;
        r_info <= info_in;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      result      <= '0;
      info_out    <= '0;
      f_invalid   <= 1'b0;
      f_divbyzero <= 1'b0;
      f_overflow  <= 1'b0;
      f_underflow <= 1'b0;
      f_inexact   <= 1'b0;
    end else if (w_fire) begin
      result      <= r_res;
      info_out    <= r_info;
      f_invalid   <= r_flg[4];
      f_divbyzero <= r_flg[3];
      f_overflow  <= r_flg[2];
      f_underflow <= r_flg[1];
      f_inexact   <= r_flg[0];
    end else begin
      info_out[0] <= 1'b0;
    end
  end

  assign busy = (r_state != S_IDLE) | a_wait;

endmodule
